// File: rtl/conv_adder_sched.sv
// conv_adder_sched: job scheduler and credit controller for the 16-lane conv 2-D adder bank
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   start, cfg_num_pixels/groups    job start (accepted in IDLE) and job size
//   in_avail                        upstream products present for the current pixel
//   wgt_req, wgt_group, wgt_ack     weight reload handshake, one per group
//   adder_valid_in, adder_valid_out issue pulse to / result strobe from the adder bank
//   buf_wr_en, buf_rd_en            external result FIFO write / read strobes
//   out_valid, out_ready            head result handshake with the consumer
//   out_group, out_pixel            {group, pixel} tag of the head result
//   busy, done, err                 status: not idle, completion pulse, sticky error
// Optional feature: define CONV_SCHED_TIMEOUT_EN to add the result watchdog.
module conv_adder_sched #(
    parameter int DEPTH       = 8,
    parameter int PIX_W       = 16,
    parameter int GRP_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] cfg_num_pixels,
    input  logic [GRP_W-1:0] cfg_num_groups,
    input  logic             in_avail,
    output logic             wgt_req,
    output logic [GRP_W-1:0] wgt_group,
    input  logic             wgt_ack,
    output logic             adder_valid_in,
    input  logic             adder_valid_out,
    output logic             buf_wr_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             buf_rd_en,
    output logic [GRP_W-1:0] out_group,
    output logic [PIX_W-1:0] out_pixel,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic [2:0] {IDLE, WLOAD, RUN, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [PIX_W-1:0] num_pix, pix;
    logic [GRP_W-1:0] num_grp, grp;
    logic [AW:0] occ, res;
    logic [AW-1:0] wp, rp;
    logic [GRP_W+PIX_W-1:0] tags [DEPTH];
    logic start_acc, issue, last_pix, last_grp, spur, tmo;
    assign start_acc = state == IDLE && start;
    assign issue = state == RUN && in_avail && occ < FULL;
    assign last_pix = pix == num_pix - 1'b1;
    assign last_grp = grp == num_grp - 1'b1;
    // occ == res means nothing is in the bank pipeline, so a result strobe is unexpected
    assign spur = adder_valid_out && occ == res && !rst;
    assign wgt_req = state == WLOAD;
    assign wgt_group = grp;
    assign adder_valid_in = issue;
    assign buf_wr_en = adder_valid_out && occ != res && !rst;
    assign out_valid = res != 0;
    assign buf_rd_en = out_valid && out_ready && !rst;
    // tag FIFO holds exactly occ entries; mask stale contents when empty
    assign {out_group, out_pixel} = occ != 0 ? tags[rp] : '0;
    assign busy = state != IDLE;
    assign done = state == DONE;
`ifdef CONV_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC) + 1;
    logic [WW-1:0] wd;
    assign tmo = occ != res && !adder_valid_out && wd == WW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk) begin
        if (rst || adder_valid_out || occ == res || tmo) wd <= '0;
        else wd <= wd + 1'b1;
    end
`else
    assign tmo = 1'b0 && TIMEOUT_CYC > 0;
`endif
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  state_n = start ? (cfg_num_pixels == 0 || cfg_num_groups == 0 ? DONE : WLOAD) : IDLE;
            WLOAD: state_n = wgt_ack ? RUN : WLOAD;
            RUN:   state_n = issue && last_pix ? (last_grp ? DRAIN : WLOAD) : RUN;
            DRAIN: state_n = occ == 0 ? DONE : DRAIN;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (tmo) state_n = DONE;
    end
    always_ff @(posedge clk) begin
        if (issue) tags[wp] <= {grp, pix};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            num_pix <= '0;
            num_grp <= '0;
            pix     <= '0;
            grp     <= '0;
            occ     <= '0;
            res     <= '0;
            wp      <= '0;
            rp      <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_n;
            if (start_acc) begin
                num_pix <= cfg_num_pixels;
                num_grp <= cfg_num_groups;
                pix     <= '0;
                grp     <= '0;
            end else if (issue) begin
                pix <= last_pix ? '0 : pix + 1'b1;
                grp <= last_pix ? grp + 1'b1 : grp;
            end
            err <= spur || tmo || (err && !start_acc);
            if (tmo) begin
                occ <= '0;
                res <= '0;
                wp  <= '0;
                rp  <= '0;
            end else begin
                occ <= occ + (AW+1)'(issue) - (AW+1)'(buf_rd_en);
                res <= res + (AW+1)'(buf_wr_en) - (AW+1)'(buf_rd_en);
                wp  <= wp + AW'(issue);
                rp  <= rp + AW'(buf_rd_en);
            end
        end
    end
endmodule

// File: tb/tb_conv_adder_sched.sv
// tb_conv_adder_sched: randomized self-checking bench with a job-level reference model
module tb_conv_adder_sched;
    localparam int D = 8;
    logic clk = 0, rst = 1, start = 0, in_avail = 0, wgt_ack = 0, adder_valid_out = 0, out_ready = 0;
    logic [15:0] cfg_num_pixels = 0;
    logic [3:0] cfg_num_groups = 0;
    logic wgt_req, adder_valid_in, buf_wr_en, out_valid, buf_rd_en, busy, done, err;
    logic [3:0] wgt_group, out_group;
    logic [15:0] out_pixel;
    int checks = 0, errors = 0;
    int n_iss = 0, n_wreq = 0, n_done = 0, lat = 5, wcnt = 0, wdly = 2;
    bit chk_en = 1, rnd = 0, mute = 0, inj = 0, iss_s = 0, wreq_prev = 0;
    logic [7:0] pipe = 0;
    logic [19:0] tagq[$], got[$];
    int m_occ = 0, m_res = 0;
    bit m_err = 0, active = 0, exp_done = 0, wl = 0, drain = 0;
    logic [3:0] mgrp = 0, ng = 0;
    logic [15:0] mpix = 0, np = 0;
    conv_adder_sched dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_pixels(cfg_num_pixels),
        .cfg_num_groups(cfg_num_groups), .in_avail(in_avail), .wgt_req(wgt_req),
        .wgt_group(wgt_group), .wgt_ack(wgt_ack), .adder_valid_in(adder_valid_in),
        .adder_valid_out(adder_valid_out), .buf_wr_en(buf_wr_en), .out_valid(out_valid),
        .out_ready(out_ready), .buf_rd_en(buf_rd_en), .out_group(out_group),
        .out_pixel(out_pixel), .busy(busy), .done(done), .err(err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask
    // bank model, weight loader and random handshake drivers
    initial forever begin
        @(posedge clk);
        #1;
        pipe = {pipe[6:0], iss_s};
        adder_valid_out = (pipe[lat-1] && !mute) || inj;
        if (rnd) begin
            in_avail = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
        end
        if (wgt_req) begin
            wcnt++;
            wgt_ack = wcnt == wdly;
        end else begin
            wcnt = 0;
            wgt_ack = 0;
            wdly = rnd ? $urandom_range(1, 3) : 2;
        end
    end
    // reference model and per-cycle compare
    always @(negedge clk) begin
        bit ei, er, ew, nd;
        if (rst) begin
            m_occ = 0; m_res = 0; m_err = 0; active = 0; exp_done = 0; wl = 0; drain = 0;
            mgrp = 0; mpix = 0; iss_s = 0; wreq_prev = 0;
            tagq.delete();
        end else begin
            ei = active && !wl && !drain && !exp_done && in_avail && m_occ < D;
            er = m_res != 0 && out_ready;
            ew = adder_valid_out && m_occ != m_res;
            iss_s = adder_valid_in;
            if (chk_en) begin
                chk("adder_valid_in", {31'h0, adder_valid_in}, {31'h0, ei});
                chk("out_valid", {31'h0, out_valid}, {31'h0, m_res != 0});
                chk("buf_rd_en", {31'h0, buf_rd_en}, {31'h0, er});
                chk("buf_wr_en", {31'h0, buf_wr_en}, {31'h0, ew});
                chk("err", {31'h0, err}, {31'h0, m_err});
                chk("busy", {31'h0, busy}, {31'h0, active});
                chk("done", {31'h0, done}, {31'h0, exp_done});
                chk("wgt_req", {31'h0, wgt_req}, {31'h0, wl});
                if (wl) chk("wgt_group", {28'h0, wgt_group}, {28'h0, mgrp});
                if (m_res != 0) chk("tag", {12'h0, out_group, out_pixel}, {12'h0, tagq[0]});
            end
            if (adder_valid_in) n_iss++;
            if (wgt_req && !wreq_prev) n_wreq++;
            wreq_prev = wgt_req;
            if (done) n_done++;
            if (buf_rd_en) got.push_back({out_group, out_pixel});
            nd = 0;
            if (!active && start) begin
                m_err = 0; np = cfg_num_pixels; ng = cfg_num_groups; mgrp = 0; mpix = 0; active = 1;
                if (np == 0 || ng == 0) nd = 1; else wl = 1;
            end else if (exp_done) active = 0;
            else if (wl && wgt_ack) wl = 0;
            if (drain && m_occ == 0) begin
                nd = 1;
                drain = 0;
            end
            if (ei) begin
                tagq.push_back({mgrp, mpix});
                if (mpix == np - 1) begin
                    mpix = 0;
                    mgrp++;
                    if (mgrp == ng) drain = 1; else wl = 1;
                end else mpix++;
            end
            if (er) void'(tagq.pop_front());
            if (adder_valid_out && m_occ == m_res) m_err = 1;
            m_occ = m_occ + int'(ei) - int'(er);
            m_res = m_res + int'(ew) - int'(er);
            exp_done = nd;
        end
    end
    task automatic do_reset();
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 0;
    endtask
    task automatic do_start(input int g, input int p);
        @(posedge clk); #1;
        cfg_num_groups = 4'(g); cfg_num_pixels = 16'(p); start = 1;
        @(posedge clk); #1; start = 0;
    endtask
    task automatic wait_done(input int maxc);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got 0 want 1");
        end
        @(negedge clk);
    endtask
    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "stuck");
    end
    initial begin
        int tot;
        do_reset();
        @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_wgt_req", {31'h0, wgt_req}, 0);
        chk("rst_err", {31'h0, err}, 0);
        // 2 groups x 3 pixels, continuous flow
        in_avail = 1; out_ready = 1; lat = 5;
        n_iss = 0; n_wreq = 0; n_done = 0; got.delete();
        do_start(2, 3);
        wait_done(200);
        chk("job_issues", n_iss, 6);
        chk("job_wreqs", n_wreq, 2);
        chk("job_dones", n_done, 1);
        chk("job_err", {31'h0, err}, 0);
        chk("job_ntags", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++)
            chk("job_tag", {12'h0, got[i]}, (i / 3) * 32'h10000 + i % 3);
        // throttle: consumer stalled, 1 x 20 job
        out_ready = 0; n_iss = 0;
        do_start(1, 20);
        repeat (40) @(negedge clk);
        chk("throttle_issues", n_iss, 8);
        @(posedge clk); #1; out_ready = 1;
        @(negedge clk);
        chk("resume_rd", {31'h0, buf_rd_en}, 1);
        chk("resume_blocked", {31'h0, adder_valid_in}, 0);
        @(negedge clk);
        chk("resume_issue", {31'h0, adder_valid_in}, 1);
        wait_done(400);
        // zero pixel job
        n_wreq = 0; n_iss = 0;
        do_start(3, 0);
        @(negedge clk);
        chk("zero_done", {31'h0, done}, 1);
        @(negedge clk);
        chk("zero_wreq", n_wreq, 0);
        chk("zero_iss", n_iss, 0);
        // spurious result while idle
        @(negedge clk); inj = 1;
        @(negedge clk); inj = 0;
        chk("spur_wr", {31'h0, buf_wr_en}, 0);
        @(negedge clk);
        chk("spur_err", {31'h0, err}, 1);
        do_start(1, 1);
        @(negedge clk);
        chk("start_clears_err", {31'h0, err}, 0);
        wait_done(100);
        // randomized jobs
        rnd = 1; n_iss = 0; tot = 0;
        for (int j = 0; j < 8; j++) begin
            int g, p;
            g = $urandom_range(1, 3); p = $urandom_range(1, 6); lat = $urandom_range(1, 8);
            tot += g * p;
            do_start(g, p);
            wait_done(2000);
        end
        chk("rand_issues", n_iss, tot);
        // reset mid-run with 4 in flight
        rnd = 0; in_avail = 1; out_ready = 0; lat = 5; n_iss = 0;
        do_start(1, 10);
        for (int i = 0; i < 100 && n_iss < 4; i++) @(negedge clk);
        chk("rst_inflight", n_iss, 4);
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        chk("mid_rst_outs", {20'h0, wgt_req, adder_valid_in, buf_wr_en, out_valid, buf_rd_en,
                             busy, done, err, out_group}, 0);
        chk("mid_rst_pix", {16'h0, out_pixel}, 0);
        repeat (10) @(negedge clk);
        chk("late_result_err", {31'h0, err}, 1);
        do_reset();
`ifdef CONV_SCHED_TIMEOUT_EN
        begin
            int c;
            bit seen;
            chk_en = 0; mute = 1; out_ready = 1; in_avail = 1; c = 0; seen = 0;
            do_start(1, 1);
            for (int i = 0; i < 50 && !adder_valid_in; i++) @(negedge clk);
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                c++;
                seen = done;
            end
            chk("tmo_cycles", c, 65);
            chk("tmo_err", {31'h0, err}, 1);
            chk("tmo_out_valid", {31'h0, out_valid}, 0);
            mute = 0;
            do_reset();
            chk_en = 1;
        end
`endif
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
